// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and chain-length limits for the scan controller
package scan_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} scan_state_t;
  localparam int SCAN_N_MIN = 2;
  localparam int SCAN_N_MAX = 64;
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: W-bit shift register with parallel load, LSB serial input, MSB-first serial output
module scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  input  logic         sh_i,
  input  logic         si_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  // parallel load wins over shift; otherwise hold
  always_comb q_d = ld_i ? d_i : (sh_i ? {q_q[W-2:0], si_i} : q_q);
  // storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: loads a parallel vector into a scan-mux chain, optionally captures once, unloads it serially
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Start,
  input  logic         CapEn,
  input  logic [N-1:0] ScanIn,
  input  logic         SDO,
  output logic         Test,
  output logic         Load,
  output logic         SDI,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] ScanOut
);
  scan_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic cap_q, cap_d;
  logic test_q, test_d, load_q, load_d, busy_q, busy_d, done_q, done_d;
  logic [N-1:0] scan_out_q, scan_out_d;
  logic [N-1:0] ld_vec, res_vec;
  logic accept, last, unused_bits;

  assign accept = (state_q == IDLE) && Start;
  assign last   = (count_q == CW'(1));

  // load vector drains MSB first onto SDI and backfills zeros, so SDI is 0 once the chain is loaded
  scan_shreg #(.W(N)) u_load (
    .clk(Clock), .rst_n(nReset), .ld_i(accept), .d_i(ScanIn),
    .sh_i(state_q == SHIFT_IN), .si_i(1'b0), .q_o(ld_vec)
  );

  // result collects SDO; the final sample is merged directly into ScanOut so it lines up with Done
  scan_shreg #(.W(N)) u_res (
    .clk(Clock), .rst_n(nReset), .ld_i(1'b0), .d_i('0),
    .sh_i(state_q == SHIFT_OUT), .si_i(SDO), .q_o(res_vec)
  );

  assign unused_bits = ^{ld_vec[N-2:0], res_vec[N-1]};

  // state and registered outputs
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cap_q      <= 1'b0;
      test_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scan_out_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cap_q      <= cap_d;
      test_q     <= test_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scan_out_q <= scan_out_d;
    end

  // next-state: shift phases end on the exact count==1 compare
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = Start ? SHIFT_IN : IDLE;
      SHIFT_IN:  state_d = last ? (cap_q ? CAPTURE : SHIFT_OUT) : SHIFT_IN;
      CAPTURE:   state_d = SHIFT_OUT;
      SHIFT_OUT: state_d = last ? DONE : SHIFT_OUT;
      default:   state_d = IDLE;
    endcase
  end

  // outputs are decoded from the next state so they are registered yet aligned with it
  always_comb begin
    cap_d      = accept ? CapEn : cap_q;
    count_d    = (state_d == SHIFT_IN || state_d == SHIFT_OUT)
                 ? ((state_d != state_q) ? CW'(N) : count_q - CW'(1)) : '0;
    test_d     = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
    load_d     = (state_d == CAPTURE);
    busy_d     = (state_d == SHIFT_IN) || (state_d == CAPTURE) || (state_d == SHIFT_OUT);
    done_d     = (state_d == DONE);
    scan_out_d = done_d ? {res_vec[N-2:0], SDO} : scan_out_q;
  end

  assign Test    = test_q;
  assign Load    = load_q;
  assign SDI     = ld_vec[N-1];
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign ScanOut = scan_out_q;
endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: drives scan_ctrl into a model chain of scan-mux cells with D=~Q and scores the unloads
module tb_scan_ctrl;
  import scan_pkg::*;
  localparam int N = 8;

  logic Clock = 1'b0, nReset = 1'b0, Start = 1'b0, CapEn = 1'b0, SDO;
  logic [N-1:0] ScanIn = '0;
  logic Test, Load, SDI, Busy, Done;
  logic [N-1:0] ScanOut;
  logic [N-1:0] chain = '0;

  typedef struct {
    logic [N-1:0] si;
    logic         cap;
    logic         inj;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;
  typedef struct {
    logic [N-1:0] out;
    int           lat;
  } sb_t;

  sb_t exp_q[$];
  vec_t vecs[7];
  int vectors = 0, miscompares = 0;

  scan_ctrl #(.N(N)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .CapEn(CapEn), .ScanIn(ScanIn),
    .SDO(SDO), .Test(Test), .Load(Load), .SDI(SDI), .Busy(Busy), .Done(Done), .ScanOut(ScanOut)
  );

  always #5 Clock = ~Clock;

  // chain model: cell0 takes SDI on shift, every cell takes ~Q on load, otherwise hold
  always @(posedge Clock)
    if (Test) chain <= {chain[N-2:0], SDI};
    else if (Load) chain <= ~chain;
  assign SDO = chain[N-1];

  always @(negedge Clock)
    if (nReset) begin
      if (Test && Load) begin miscompares++; $display("FAIL test_and_load: got both 1, required never both"); end
      if (Done && Busy) begin miscompares++; $display("FAIL busy_with_done: got Busy=1, required 0"); end
      if (dut.state_q == IDLE && Test) begin miscompares++; $display("FAIL test_in_idle: got Test=1, required 0"); end
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle_window(input string name, input int cycles);
    int dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock); #1;
      if (Done || Busy) dones++;
    end
    chk(name, dones, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int edges = 0, tests = 0, load_cyc = 0, load_pos = -1;
    bit seen = 0;
    sb_t e;
    @(negedge Clock);
    ScanIn = v.si; CapEn = v.cap; Start = 1'b1;
    exp_q.push_back('{v.exp, v.lat});
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("busy_after_start", Busy, 1);
    while (edges < 60) begin
      if (Load) begin load_cyc++; load_pos = tests; end
      if (Test) tests++;
      if (Done) begin
        seen = 1;
        e = exp_q.pop_front();
        chk("scan_out", ScanOut, e.out);
        chk("done_latency", edges + 1, e.lat);
        break;
      end
      Start = v.inj && (edges == 2 || edges == 9);
      @(posedge Clock); #1;
      edges++;
    end
    Start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    chk("test_cycles", tests, 2 * N);
    chk("load_cycles", load_cyc, v.cap);
    if (v.cap) chk("load_position", load_pos, N);
    chk("chain_flushed", chain, 0);
    idle_window("no_extra_done", 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 2 * N + 1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'h5A, 2 * N + 2};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 2 * N + 1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 2 * N + 1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 2 * N + 1};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h01, 2 * N + 1};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h80, 2 * N + 1};
    #12;
    chk("reset_state", {Test, Load, SDI, Busy, Done, ScanOut}, 0);
    @(negedge Clock) nReset = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge Clock);
    ScanIn = 8'hA5; CapEn = 1'b0; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #2 nReset = 1'b0;
    #1;
    chk("reset_test_drop", Test, 0);
    chk("reset_outputs", {Test, Load, SDI, Busy, Done, ScanOut}, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) nReset = 1'b1;
    idle_window("no_done_after_abort", 30);
    run_vec('{8'h3C, 1'b0, 1'b0, 8'h3C, 2 * N + 1});
    run_vec('{8'h3C, 1'b1, 1'b0, 8'hC3, 2 * N + 2});
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Serial-side controller for a scan chain built from scan-mux cells, where each cell's next state is M = Test ? SDI : (Load ? D : Q).
- Loads an N-bit parallel vector into the chain, optionally fires one functional capture cycle, then unloads the chain serially through SDO into a parallel result word.
- Sits between the test access logic and the chain. It drives Test, Load and SDI into the chain and reads SDO back.

Parameters:
- N, 8, scan chain length in cells; legal range 2..64.
- CW, $clog2(N+1), bit-count counter width; derived, not overridden.

Ports:
- Clock  input  1  system clock; chain flops share this clock and edge.
- nReset  input  1  asynchronous active-low reset.
- Start  input  1  single-cycle request; sampled only in IDLE.
- CapEn  input  1  sampled with Start; 1 = insert a capture cycle between load and unload.
- ScanIn  input  N  vector to load; cell i receives ScanIn[i].
- SDO  input  1  serial output of chain cell N-1.
- Test  output  1  to every cell; 1 = shift.
- Load  output  1  to every cell; 1 = capture D when Test=0.
- SDI  output  1  serial input to chain cell 0.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle pulse when ScanOut is valid.
- ScanOut  output  N  unloaded chain contents; ScanOut[i] = cell i. Held until the next Done.

Behaviour:
- All outputs registered. Reset values: Test=0, Load=0, SDI=0, Busy=0, Done=0, ScanOut=0, state=IDLE, count=0.
- IDLE:
  - Test=0, Load=0, so the chain holds Q.
  - Start=1 latches ScanIn into the shift register and CapEn into capflag, sets count=N and Busy=1, and moves to SHIFT_IN.
- SHIFT_IN, N cycles:
  - Test=1, Load=0.
  - SDI presents the shift-register bits MSB first: ScanIn[N-1], ScanIn[N-2], ..., ScanIn[0]. After N edges, cell i holds ScanIn[i].
  - count decrements each edge.
  - At count=1, go to CAPTURE if capflag=1, else to SHIFT_OUT with count reloaded to N.
- CAPTURE, exactly 1 cycle:
  - Test=0, Load=1, SDI=0; the chain takes D.
  - Then go to SHIFT_OUT with count=N.
- SHIFT_OUT, N cycles:
  - Test=1, Load=0, SDI=0; the chain is flushed to zeros.
  - On each edge SDO is sampled into result: result <= {result[N-2:0], SDO}. The first sample (cell N-1) ends at result[N-1].
  - At count=1, go to DONE.
- DONE, 1 cycle:
  - ScanOut <= result, Done=1, Busy=0, Test=0, Load=0. Then IDLE.
- Total latency from the Start edge to the Done-high cycle: 2N+2 cycles with capture, 2N+1 without.
- Start while Busy is ignored. It is not queued.
- Start in the DONE cycle is ignored; accepted from IDLE only.
- Test and Load are never both driven 1. Capture (Load=1) happens only in CAPTURE.
- nReset low at any time forces the reset values immediately, and Test drops to 0 at once. The chain is then left in hold with partial contents; no Done is produced for the aborted operation.
- Counter width CW must hold N without overflow. The count=1 terminal compare is exact; no wrap.

Decomposition:
- scan_pkg holds the state enum scan_state_t {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} and the constants SCAN_N_MIN=2 and SCAN_N_MAX=64.
- One sub-module, scan_shreg: N-bit shift register with parallel load, MSB-out serial output and LSB serial input. Instantiate it twice, once for the load vector and once for the result.

Test Plan:
- Loopback through a model of 8 scan-mux cells with D=~Q per cell, N=8:
  - ScanIn=8'hA5, CapEn=0 -> ScanOut=8'hA5 with Done at 2N+1=17 cycles after Start; the chain is all zeros afterwards.
- Same model, ScanIn=8'hA5, CapEn=1:
  - Load=1 for exactly one cycle, between the 8th and 9th Test=1 cycles.
  - ScanOut=8'h5A, Done at 18 cycles.
- Start pulsed again on cycles 3 and 10 of a run -> ignored. Exactly one Done; ScanOut=8'hA5.
- nReset asserted mid-SHIFT_IN (cycle 4), released 2 cycles later:
  - Test=0 immediately; all outputs at reset values; no Done.
  - A following Start with 8'h3C -> ScanOut=8'h3C.
- Boundary vectors with N=8, CapEn=0 -> 8'h00, 8'hFF, 8'h01 and 8'h80 each return unchanged; 8'h01 confirms bit order, cell 0 → ScanOut[0].
- Assertion throughout: never (Test && Load); Busy==0 whenever Done==1; Test==0 in IDLE.
